// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: packs WIDTH bits MSB-first into a word
// and hands it downstream over valid/ready, stalling the serial source when full.
module sipo_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             valid_nxt;
    logic             accept;
    logic             last;
    logic             consume;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: park a completed word in shreg when the output slot is still occupied
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FILL: begin
                if (bit_valid && (cnt == CNT_LAST) && out_valid && !out_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (out_ready) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        bit_ready = (state == S_FILL);
        accept    = bit_valid && (state == S_FILL);
        last      = (cnt == CNT_LAST);
        consume   = out_valid && out_ready;
        nxt       = {shreg[WIDTH-2:0], bit_in};
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        data_nxt  = out_data;
        valid_nxt = out_valid;

        // A consume frees the slot unless a new word lands on the same edge
        if (consume) begin
            valid_nxt = 1'b0;
        end

        unique case (state)
            S_FILL: begin
                if (accept) begin
                    shreg_nxt = nxt;
                    if (last) begin
                        cnt_nxt = '0;
                        if (!out_valid || out_ready) begin
                            data_nxt  = nxt;
                            valid_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (out_ready) begin
                    data_nxt  = shreg;
                    valid_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
        end
    end

endmodule
